// File: rtl/pc_trace_filter.sv
// Filters the core retire stream into start, discontinuity and sync PC records and paces them out one per serial frame.
// Build option: define PC_TRACE_LOOP_SUPPRESS_EN to drop repeated identical discontinuity records (tight loops).
module pc_trace_filter #(
  parameter int FIFO_DEPTH   = 8,
  parameter int DRAIN_CYCLES = 33,
  parameter int SYNC_PERIOD  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sleep,
  input  logic        trace_en,
  input  logic        retire_valid,
  input  logic [31:0] retire_pc,
  output logic        debug_enq_valid,
  output logic [31:0] debug_w_data,
  output logic [15:0] drop_cnt,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SYNC_PERIOD);
  localparam int HW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
  localparam logic [SW-1:0] SYNC_ONE  = SW'(1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(DRAIN_CYCLES - 1);

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic          have_last_q, have_last_d;
  logic [SW-1:0] sync_cnt_q, sync_cnt_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;
  logic [15:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;

  logic        full, empty, retire_ok, discont, rec_sync, rec;
  logic        suppress, push_req, push, drop, pop;
  logic [31:0] rec_word;

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign retire_ok = retire_valid & trace_en & ~sleep;
  assign discont   = have_last_q && (retire_pc != last_pc_q + 32'd4);
  assign rec_sync  = have_last_q && !discont && (sync_cnt_q == SYNC_LAST);
  assign rec       = retire_ok && (!have_last_q || discont || rec_sync);
  // S bit is set for start and sync records, clear only for discontinuities
  assign rec_word  = {retire_pc[31:1], ~discont};

`ifdef PC_TRACE_LOOP_SUPPRESS_EN
  logic [31:0] last_push_q;

  assign suppress = discont && (rec_word == last_push_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_push_q <= '0;
    end else if (sleep) begin
      last_push_q <= '0;
    end else if (push) begin
      last_push_q <= rec_word;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign push_req = rec && !suppress;
  assign push     = push_req && !full;
  assign drop     = push_req && full;
  assign pop      = !empty && (holdoff_q == '0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    holdoff_d   = holdoff_q;
    have_last_d = have_last_q;
    sync_cnt_d  = sync_cnt_q;
    last_pc_d   = last_pc_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    drop_d      = drop_q;
    ovf_d       = ovf_q;
    if (sleep) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      holdoff_d   = '0;
      have_last_d = 1'b0;
      sync_cnt_d  = '0;
    end else begin
      if (holdoff_q != '0) holdoff_d = holdoff_q - HOLD_ONE;
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        valid_d   = 1'b1;
        data_d    = mem_q[rd_ptr_q[AW-1:0]];
        holdoff_d = HOLD_LOAD;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (drop) begin
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        ovf_d = 1'b1;
      end
      if (!trace_en) begin
        have_last_d = 1'b0;
        sync_cnt_d  = '0;
      end else if (retire_valid) begin
        last_pc_d   = retire_pc;
        have_last_d = 1'b1;
        sync_cnt_d  = rec ? '0 : sync_cnt_q + SYNC_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      holdoff_q   <= '0;
      have_last_q <= 1'b0;
      sync_cnt_q  <= '0;
      last_pc_q   <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      drop_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      holdoff_q   <= holdoff_d;
      have_last_q <= have_last_d;
      sync_cnt_q  <= sync_cnt_d;
      last_pc_q   <= last_pc_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= rec_word;
  end

  assign debug_enq_valid = valid_q;
  assign debug_w_data    = data_q;
  assign drop_cnt        = drop_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_pc_trace_filter.sv
// Bench for pc_trace_filter: directed scenarios then randomized retire traffic,
// every cycle compared against a record-level reference model.
module tb_pc_trace_filter;

  localparam int DEPTH = 8;
  localparam int DRAIN = 33;
  localparam int SYNC  = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sleep = 1'b0;
  logic        trace_en = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = '0;
  logic        debug_enq_valid;
  logic [31:0] debug_w_data;
  logic [15:0] drop_cnt;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [31:0] m_q[$];
  bit          m_have_last;
  logic [31:0] m_last_pc;
  int          m_since_rec;
  longint      m_cyc = 0;
  longint      m_next_pop;
  bit          m_v;
  logic [31:0] m_d;
  int          m_drops;
  bit          m_ovf;
  logic [31:0] m_last_push;

  logic [31:0] cap_w[$];
  longint      cap_c[$];

  pc_trace_filter #(.FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN), .SYNC_PERIOD(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sleep(sleep), .trace_en(trace_en),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .debug_enq_valid(debug_enq_valid), .debug_w_data(debug_w_data),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_have_last = 1'b0;
    m_last_pc   = '0;
    m_since_rec = 0;
    m_next_pop  = 0;
    m_v         = 1'b0;
    m_d         = '0;
    m_drops     = 0;
    m_ovf       = 1'b0;
    m_last_push = '0;
  endtask

  // One clock edge of the specified behaviour, seen as records and a paced queue
  task automatic model_edge(bit rv, logic [31:0] pc, bit en, bit slp);
    bit          do_pop, was_full, is_rec, s_bit, supp;
    logic [31:0] w;
    if (slp) begin
      m_q.delete();
      m_have_last = 1'b0;
      m_since_rec = 0;
      m_v         = 1'b0;
      m_next_pop  = 0;
      m_last_push = '0;
    end else begin
      do_pop   = (m_q.size() != 0) && (m_cyc >= m_next_pop);
      was_full = (m_q.size() == DEPTH);
      is_rec = 1'b0;
      s_bit  = 1'b1;
      supp   = 1'b0;
      if (rv && en) begin
        if (!m_have_last) is_rec = 1'b1;
        else if (pc != m_last_pc + 32'd4) begin is_rec = 1'b1; s_bit = 1'b0; end
        else if (m_since_rec == SYNC - 1) is_rec = 1'b1;
        if (is_rec) m_since_rec = 0; else m_since_rec++;
        m_have_last = 1'b1;
        m_last_pc   = pc;
      end else if (!en) begin
        m_have_last = 1'b0;
        m_since_rec = 0;
      end
      w = {pc[31:1], s_bit};
`ifdef PC_TRACE_LOOP_SUPPRESS_EN
      if (is_rec && !s_bit && w == m_last_push) supp = 1'b1;
`endif
      m_v = do_pop;
      if (do_pop) begin
        m_d = m_q.pop_front();
        m_next_pop = m_cyc + DRAIN;
      end
      if (is_rec && !supp) begin
        if (was_full) begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end else begin
          m_q.push_back(w);
          m_last_push = w;
        end
      end
    end
    m_cyc++;
  endtask

  task automatic step(bit rv, logic [31:0] pc, bit en, bit slp);
    retire_valid = rv;
    retire_pc    = pc;
    trace_en     = en;
    sleep        = slp;
    @(posedge clk);
    model_edge(rv, pc, en, slp);
    @(negedge clk);
    check("enq_valid", {31'd0, debug_enq_valid}, {31'd0, m_v});
    if (m_v) check("w_data", debug_w_data, m_d);
    check("drop_cnt", {16'd0, drop_cnt}, 32'(m_drops));
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (debug_enq_valid) begin
      cap_w.push_back(debug_w_data);
      cap_c.push_back(m_cyc);
    end
  endtask

  task automatic idle(int n, bit en);
    repeat (n) step(1'b0, 32'd0, en, 1'b0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_enq_valid", {31'd0, debug_enq_valid}, 32'd0);
    check("rst_w_data", debug_w_data, 32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    model_reset();
    retire_valid = 1'b0;
    sleep        = 1'b0;
    trace_en     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cap_w.delete();
    cap_c.delete();
  endtask

  initial begin
    logic [31:0] pc;
    bit          rv, en, slp;
    longint      t0;
    int          thr;

    // 1: sequential run gives one start record, two cycles after the retire
    do_reset();
    t0 = m_cyc;
    step(1, 32'h1000, 1, 0);
    step(1, 32'h1004, 1, 0);
    step(1, 32'h1008, 1, 0);
    idle(60, 1);
    check("t1_count", cap_w.size(), 1);
    if (cap_w.size() == 1) begin
      check("t1_word", cap_w[0], 32'h0000_1001);
      check("t1_latency", 32'(cap_c[0] - t0), 32'd2);
    end

    // 2: jumps, back-to-back discontinuities paced 33 cycles apart
    do_reset();
    step(1, 32'h2000, 1, 0);
    step(1, 32'h2004, 1, 0);
    step(1, 32'h2008, 1, 0);
    step(1, 32'h3000, 1, 0);
    step(1, 32'h4000, 1, 0);
    step(1, 32'h5000, 1, 0);
    idle(140, 1);
    check("t2_count", cap_w.size(), 4);
    if (cap_w.size() == 4) begin
      check("t2_w0", cap_w[0], 32'h0000_2001);
      check("t2_w1", cap_w[1], 32'h0000_3000);
      check("t2_w2", cap_w[2], 32'h0000_4000);
      check("t2_w3", cap_w[3], 32'h0000_5000);
      for (int i = 1; i < 4; i++) check("t2_spacing", 32'(cap_c[i] - cap_c[i-1]), DRAIN);
    end

    // 3: long sequential run forces a sync record on the 257th retire
    do_reset();
    t0 = m_cyc;
    for (int i = 0; i < 300; i++) step(1, 32'(i * 4), 1, 0);
    idle(80, 1);
    check("t3_count", cap_w.size(), 2);
    if (cap_w.size() == 2) begin
      check("t3_start", cap_w[0], 32'h0000_0001);
      check("t3_sync", cap_w[1], 32'h0000_0401);
      check("t3_sync_time", 32'(cap_c[1] - t0), 32'd258);
    end

    // 4: start then 12 consecutive discontinuities overrun the local FIFO
    do_reset();
    step(1, 32'h9000, 1, 0);
    for (int i = 1; i <= 12; i++) step(1, 32'h9000 + 32'(i * 32'h100), 1, 0);
    idle(300, 1);
    check("t4_count", cap_w.size(), 9);
    if (cap_w.size() == 9) begin
      check("t4_start", cap_w[0], 32'h0000_9001);
      for (int k = 1; k <= 8; k++) check("t4_word", cap_w[k], 32'h9000 + 32'(k * 32'h100));
    end
    check("t4_drop_cnt", {16'd0, drop_cnt}, 32'd4);
    check("t4_overflow", {31'd0, overflow}, 32'd1);

    // 5: sleep with records queued and holdoff running; drop count survives
    step(0, 32'd0, 0, 0);
    step(1, 32'hA000, 1, 0);
    for (int i = 1; i <= 5; i++) step(1, 32'hA000 + 32'(i * 32'h100), 1, 0);
    cap_w.delete();
    cap_c.delete();
    step(0, 32'd0, 1, 1);
    idle(80, 1);
    check("t5_no_strobes", cap_w.size(), 0);
    t0 = m_cyc;
    step(1, 32'h8000, 1, 0);
    idle(3, 1);
    check("t5_count", cap_w.size(), 1);
    if (cap_w.size() == 1) begin
      check("t5_word", cap_w[0], 32'h0000_8001);
      check("t5_latency", 32'(cap_c[0] - t0), 32'd2);
    end
    check("t5_drop_cnt", {16'd0, drop_cnt}, 32'd4);

    // reset asserted while a frame is in flight and records are queued
    step(1, 32'hB000, 1, 0);
    step(1, 32'hB100, 1, 0);
    step(1, 32'hB200, 1, 0);
    do_reset();

    // 6: tight loop repeatedly jumping back to 0x6000
    step(1, 32'h6000, 1, 0);
    step(1, 32'h6004, 1, 0);
    repeat (10) begin
      step(1, 32'h6000, 1, 0);
      step(1, 32'h6004, 1, 0);
    end
    idle(400, 1);
`ifdef PC_TRACE_LOOP_SUPPRESS_EN
    check("t6_count", cap_w.size(), 2);
    check("t6_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`else
    check("t6_count", cap_w.size(), 9);
    check("t6_drop_cnt", {16'd0, drop_cnt}, 32'd2);
`endif
    if (cap_w.size() >= 2) begin
      check("t6_start", cap_w[0], 32'h0000_6001);
      check("t6_loop", cap_w[1], 32'h0000_6000);
    end

    // random traffic: mostly-sequential phase (syncs, PC wrap) then jump-heavy phase
    do_reset();
    for (int p = 0; p < 2; p++) begin
      pc  = (p == 0) ? 32'hFFFF_FF00 : 32'h0000_4000;
      thr = (p == 0) ? 2 : 300;
      for (int i = 0; i < 2500; i++) begin
        slp = ($urandom_range(0, 999) < 4);
        en  = ($urandom_range(0, 999) >= 6);
        rv  = ($urandom_range(0, 3) != 0);
        if (rv) begin
          if ($urandom_range(0, 999) >= thr) pc = pc + 32'd4;
          else if ($urandom_range(0, 1) == 0) pc = ($urandom_range(0, 1) == 0) ? 32'h6000 : 32'h7000;
          else pc = $urandom() & 32'hFFFF_FFFE;
        end
        step(rv, pc, en, slp);
      end
    end
    idle(300, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
